// File: rtl/satd_shift_ctrl.sv
// satd_shift_ctrl
// Sequencer for the SATD sample shift register. It captures one ORG/CUR block
// on request and streams it to the transform datapath as LANES-wide beats
// under a valid/ready handshake. It also keeps a one-deep queue of block
// requests and a wrapping count of completed blocks.
// NUM_SAMPLES must be an integer multiple of LANES.
module satd_shift_ctrl #(
    parameter int NUM_SAMPLES = 128,
    parameter int LANES       = 8,
    parameter int CNT_W       = 16,
    localparam int BEATS      = NUM_SAMPLES / LANES,
    localparam int IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dp_ready,
    output logic             load_en,
    output logic             shift,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last,
    output logic [IDX_W-1:0] beat_idx,
    output logic             busy,
    output logic             done,
    output logic             start_overrun,
    output logic [CNT_W-1:0] blk_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             pend;
    logic             pend_nxt;
    logic             overrun_nxt;
    logic [IDX_W-1:0] beat_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             consume;

    // Next-state, datapath-control outputs and request-queue bookkeeping.
    // A queued request is consumed on the way out of DONE, or from IDLE if a
    // start landed in the final DONE cycle of a block without a queued one.
    always_comb begin
        state_nxt   = state;
        pend_nxt    = pend;
        overrun_nxt = start_overrun;
        beat_nxt    = beat_idx;
        cnt_nxt     = blk_cnt;
        load_en     = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        consume     = 1'b0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start || pend) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                load_en   = 1'b1;
                beat_nxt  = '0;
                state_nxt = STREAM;
            end
            STREAM: begin
                out_valid = 1'b1;
                if (dp_ready) begin
                    if (beat_idx == LAST_IDX) begin
                        beat_nxt  = '0;
                        state_nxt = DONE;
                    end else begin
                        beat_nxt = beat_idx + IDX_ONE;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                cnt_nxt   = blk_cnt + CNT_ONE;
                state_nxt = pend ? LOAD : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        shift     = out_valid & dp_ready;
        out_first = out_valid && (beat_idx == '0);
        out_last  = out_valid && (beat_idx == LAST_IDX);

        consume = pend && ((state == IDLE) || (state == DONE));
        if (consume) begin
            pend_nxt = start;
        end else if (start && busy) begin
            if (pend) begin
                overrun_nxt = 1'b1;
            end else begin
                pend_nxt = 1'b1;
            end
        end
    end

    // Register the state and counters; reset discards any block in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            pend          <= 1'b0;
            start_overrun <= 1'b0;
            beat_idx      <= '0;
            blk_cnt       <= '0;
        end else begin
            state         <= state_nxt;
            pend          <= pend_nxt;
            start_overrun <= overrun_nxt;
            beat_idx      <= beat_nxt;
            blk_cnt       <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_satd_shift_ctrl.sv
// tb_satd_shift_ctrl
// Drives satd_shift_ctrl (and a copy with a 2-bit block counter) and checks
// every observed cycle against a block-position reference model.
module tb_satd_shift_ctrl;

    localparam int BEATS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        dp_ready;

    logic        load_en, shift, out_valid, out_first, out_last, busy, done, start_overrun;
    logic [3:0]  beat_idx;
    logic [15:0] blk_cnt;

    logic        load_en2, shift2, out_valid2, out_first2, out_last2, busy2, done2, start_overrun2;
    logic [3:0]  beat_idx2;
    logic [1:0]  blk_cnt2;

    logic [41:0] obs;
    logic [41:0] exp_vec;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Reference model: position within the current block
    // (-1 idle, 0 capture, 1..BEATS beat pos-1, BEATS+1 completion cycle).
    int m_pos     = -1;
    bit m_pend    = 1'b0;
    bit m_ovr     = 1'b0;
    int m_blocks  = 0;
    bit have_prev = 1'b0;

    satd_shift_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .dp_ready(dp_ready),
        .load_en(load_en), .shift(shift), .out_valid(out_valid),
        .out_first(out_first), .out_last(out_last), .beat_idx(beat_idx),
        .busy(busy), .done(done), .start_overrun(start_overrun), .blk_cnt(blk_cnt)
    );

    satd_shift_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .dp_ready(dp_ready),
        .load_en(load_en2), .shift(shift2), .out_valid(out_valid2),
        .out_first(out_first2), .out_last(out_last2), .beat_idx(beat_idx2),
        .busy(busy2), .done(done2), .start_overrun(start_overrun2), .blk_cnt(blk_cnt2)
    );

    assign obs = {load_en, shift, out_valid, out_first, out_last, beat_idx, busy, done,
                  start_overrun, blk_cnt,
                  load_en2, shift2, out_valid2, out_first2, out_last2, beat_idx2, busy2,
                  done2, start_overrun2, blk_cnt2};

    // Free-running clock
    always #5 clk = ~clk;

    // Move the model across one rising edge using the inputs held over that edge
    task automatic model_advance();
        if (rst === 1'b0) begin
            m_pos    = -1;
            m_pend   = 1'b0;
            m_ovr    = 1'b0;
            m_blocks = 0;
        end else if (m_pos == -1) begin
            if (start || m_pend) begin
                m_pos  = 0;
                m_pend = m_pend & start;
            end
        end else if (m_pos == BEATS + 1) begin
            m_blocks++;
            if (m_pend) begin
                m_pos  = 0;
                m_pend = start;
            end else begin
                m_pos = -1;
                if (start) m_pend = 1'b1;
            end
        end else begin
            if (start) begin
                if (m_pend) m_ovr = 1'b1;
                else        m_pend = 1'b1;
            end
            if (m_pos == 0)    m_pos = 1;
            else if (dp_ready) m_pos++;
        end
    endtask

    // Apply one cycle of inputs and compute the outputs the model expects for it
    task automatic cycle(input logic s, input logic r, input logic n);
        logic       v;
        logic [3:0] eb;
        if (have_prev) model_advance();
        have_prev = 1'b1;
        @(negedge clk);
        start    = s;
        dp_ready = r;
        rst      = n;
        cyc++;
        #1;
        v  = (m_pos >= 1) && (m_pos <= BEATS);
        eb = v ? 4'(m_pos - 1) : 4'd0;
        exp_vec = {(m_pos == 0), (v && dp_ready), v, (m_pos == 1), (m_pos == BEATS), eb,
                   (m_pos >= 0), (m_pos == BEATS + 1), m_ovr, 16'(m_blocks % 65536),
                   (m_pos == 0), (v && dp_ready), v, (m_pos == 1), (m_pos == BEATS), eb,
                   (m_pos >= 0), (m_pos == BEATS + 1), m_ovr, 2'(m_blocks % 4)};
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        tests_run++;
        if (obs !== 42'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state got=%h want=%h", obs, 42'd0);
        end
        cycle(1'b1, 1'b1, 1'b0);
        tests_run++;
        if (obs !== exp_vec) begin
            tests_failed++;
            $display("[TB] FAIL reset_hold got=%h want=%h", obs, exp_vec);
        end
        cycle(1'b0, 1'b1, 1'b1);
        tests_run++;
        if (busy !== 1'b0 || load_en !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_start_ignored busy=%b load_en=%b want 0 0", busy, load_en);
        end
    endtask

    task automatic test_basic();
        int t0, load_at, first_at, last_at, done_at, shifts;
        load_at = -1; first_at = -1; last_at = -1; done_at = -1; shifts = 0;
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        t0 = cyc;
        for (int rel = 1; rel <= 22; rel++) begin
            cycle(1'b0, 1'b1, 1'b1);
            tests_run++;
            if (obs !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL basic rel=%0d got=%h want=%h", rel, obs, exp_vec);
            end
            if (load_en === 1'b1)   load_at = cyc;
            if (out_first === 1'b1) first_at = cyc;
            if (out_last === 1'b1)  last_at = cyc;
            if (done === 1'b1)      done_at = cyc;
            if (shift === 1'b1)     shifts++;
        end
        tests_run++;
        if (load_at != t0 + 1 || first_at != t0 + 2 || last_at != t0 + 17) begin
            tests_failed++;
            $display("[TB] FAIL basic_timing load/first/last=%0d/%0d/%0d want %0d/%0d/%0d",
                     load_at - t0, first_at - t0, last_at - t0, 1, 2, 17);
        end
        tests_run++;
        if (done_at != t0 + 18 || shifts != 16) begin
            tests_failed++;
            $display("[TB] FAIL basic_done done_rel=%0d shifts=%0d want 18 16",
                     done_at - t0, shifts);
        end
    endtask

    task automatic test_backpressure();
        int t0, done_at, shifts;
        logic r;
        done_at = -1; shifts = 0;
        cycle(1'b1, 1'b1, 1'b1);
        t0 = cyc;
        for (int rel = 1; rel <= 26; rel++) begin
            r = !(rel == 5 || rel == 6 || rel == 7 || rel == 10);
            cycle(1'b0, r, 1'b1);
            tests_run++;
            if (obs !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL backpressure rel=%0d got=%h want=%h", rel, obs, exp_vec);
            end
            if (done === 1'b1)  done_at = cyc;
            if (shift === 1'b1) shifts++;
        end
        tests_run++;
        if (done_at != t0 + 22 || shifts != 16) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_done done_rel=%0d shifts=%0d want 22 16",
                     done_at - t0, shifts);
        end
    endtask

    task automatic test_back_to_back();
        int t0, d1, d2, idle_cycles, cnt_before;
        d1 = -1; d2 = -1; idle_cycles = 0;
        cnt_before = m_blocks;
        cycle(1'b1, 1'b1, 1'b1);
        t0 = cyc;
        for (int rel = 1; rel <= 40; rel++) begin
            cycle(rel == 7, 1'b1, 1'b1);
            tests_run++;
            if (obs !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back rel=%0d got=%h want=%h", rel, obs, exp_vec);
            end
            if (done === 1'b1) begin
                if (d1 < 0) d1 = cyc;
                else        d2 = cyc;
            end
            if (rel <= 36 && busy !== 1'b1) idle_cycles++;
        end
        tests_run++;
        if (d1 != t0 + 18 || d2 != t0 + 36 || idle_cycles != 0) begin
            tests_failed++;
            $display("[TB] FAIL back_to_back_timing d1=%0d d2=%0d idle=%0d want 18 36 0",
                     d1 - t0, d2 - t0, idle_cycles);
        end
        tests_run++;
        if (blk_cnt !== 16'(cnt_before + 2) || start_overrun !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL back_to_back_count blk_cnt=%0d ovr=%b want %0d 0",
                     blk_cnt, start_overrun, cnt_before + 2);
        end
    endtask

    task automatic test_overrun();
        int dones;
        dones = 0;
        cycle(1'b1, 1'b1, 1'b1);
        for (int rel = 1; rel <= 45; rel++) begin
            cycle(rel == 3 || rel == 5 || rel == 7, 1'b1, 1'b1);
            tests_run++;
            if (obs !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL overrun rel=%0d got=%h want=%h", rel, obs, exp_vec);
            end
            if (done === 1'b1) dones++;
        end
        tests_run++;
        if (dones != 2 || start_overrun !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL overrun_result dones=%0d ovr=%b busy=%b want 2 1 0",
                     dones, start_overrun, busy);
        end
    endtask

    task automatic test_reset_midstream();
        int dones;
        dones = 0;
        cycle(1'b1, 1'b1, 1'b1);
        for (int rel = 1; rel <= 8; rel++) cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        tests_run++;
        if (out_valid !== 1'b1 || beat_idx !== 4'd7) begin
            tests_failed++;
            $display("[TB] FAIL midstream_beat valid=%b beat=%0d want 1 7", out_valid, beat_idx);
        end
        cycle(1'b1, 1'b1, 1'b0);
        tests_run++;
        if (obs !== 42'd0) begin
            tests_failed++;
            $display("[TB] FAIL midstream_reset got=%h want=%h", obs, 42'd0);
        end
        for (int rel = 1; rel <= 25; rel++) begin
            cycle(1'b0, 1'b1, 1'b1);
            tests_run++;
            if (obs !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL midstream_after rel=%0d got=%h want=%h", rel, obs, exp_vec);
            end
            if (done === 1'b1) dones++;
        end
        tests_run++;
        if (dones != 0 || blk_cnt !== 16'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midstream_idle dones=%0d blk_cnt=%0d busy=%b want 0 0 0",
                     dones, blk_cnt, busy);
        end
    endtask

    task automatic test_counter_wrap();
        int seq[5] = '{1, 2, 3, 0, 1};
        int k;
        logic s, prev_done;
        k = 0; prev_done = 1'b0;
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        for (int rel = 1; rel <= 95; rel++) begin
            s = (rel == 5 || rel == 23 || rel == 41 || rel == 59);
            cycle(s, 1'b1, 1'b1);
            tests_run++;
            if (obs !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL wrap rel=%0d got=%h want=%h", rel, obs, exp_vec);
            end
            if (prev_done && k < 5) begin
                tests_run++;
                if (blk_cnt2 !== 2'(seq[k])) begin
                    tests_failed++;
                    $display("[TB] FAIL wrap_seq block=%0d blk_cnt=%0d want %0d",
                             k + 1, blk_cnt2, seq[k]);
                end
                k++;
            end
            prev_done = (done === 1'b1);
        end
        tests_run++;
        if (k != 5 || blk_cnt !== 16'd5) begin
            tests_failed++;
            $display("[TB] FAIL wrap_total blocks=%0d blk_cnt=%0d want 5 5", k, blk_cnt);
        end
    endtask

    task automatic test_random();
        logic s, r, n;
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            s = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 3) != 0);
            n = ($urandom_range(0, 299) != 0);
            cycle(s, r, n);
            tests_run++;
            if (obs !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL random i=%0d got=%h want=%h", i, obs, exp_vec);
            end
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        dp_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_reset_midstream();
        test_counter_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
